button_conditioner: RTL

// Input stage between the raw push-button pins (ui_in[2:0]) and the stopwatch

---
 rtl/button_conditioner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button input stage: per channel a 2-flop synchroniser, a debounce FSM
// with qualification counter, and registered level / press / release outputs.
module button_conditioner #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_W           = 14
) (
   input  logic             clk,
   input  logic             res,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } state_t;

   // The counter must hold DEBOUNCE_CYCLES-1 without wrapping.
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("button_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic             s1_q, s1_d;
      logic             s2_q, s2_d;
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;

      always_comb begin
         s1_d = btn_in[i];
         s2_d = s1_q;
      end

      // Any sample matching the current stable level drops back to STABLE_*,
      // so a bounce restarts qualification with no partial credit.
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state_q)
            STABLE_LO: begin
               if (s2_q) begin
                  state_d = CHECK_HI;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = '0;
               end
            end
            CHECK_HI: begin
               if (!s2_q) begin
                  state_d = STABLE_LO;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_HI;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (!s2_q) begin
                  state_d = CHECK_LO;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = '0;
               end
            end
            CHECK_LO: begin
               if (s2_q) begin
                  state_d = STABLE_HI;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = STABLE_LO;
                  level_d   = 1'b0;
                  release_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk or negedge res) begin
         if (!res) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
   end

endmodule
